quad_encoder_gen: RTL and testbench

Quadrature encoder generator: converts a stream of step/direction commands into 2-bit Gray-coded A/B channel outputs, with a programmable minimum spacing between edges. It is the transmit-side counterpart of the quadrature decoder. It drives the motor-emulation path and decoder self-test loopback, and tracks the emitted position in a signed counter.

---
 rtl/quad_encoder_gen.sv | 130 +++++++++++++
 tb/tb_quad_encoder_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen.sv
// ----------------------------------------------------------------------------
// quad_encoder_gen
//
// Quadrature encoder generator. Turns a step/direction request stream into
// Gray-coded A/B channels ({A,B}: 00 -> 01 -> 11 -> 10 -> 00 going forward),
// enforcing a programmable minimum number of clocks between edges, and keeps
// a signed count of the net steps emitted.
//
// Optional feature macro: QUAD_GEN_INDEX_EN
//   When defined, adds a registered index output z that is high exactly while
//   position[IDX_LOG2-1:0] == 0.
//
// Parameters
//   DIV_W     width of period and the internal hold counter
//   POS_W     width of the signed position counter
//   IDX_LOG2  index spacing is 2**IDX_LOG2 counts (index build only)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   step_valid  in   step request present
//   step_dir    in   step direction (1 = forward, 0 = reverse)
//   step_ready  out  a step can be accepted this cycle
//   period      in   minimum clocks between edges, sampled on acceptance
//   A, B        out  quadrature channels (registered)
//   dir         out  direction of last accepted step (registered)
//   position    out  signed net step count (registered)
//   z           out  index pulse (registered, QUAD_GEN_INDEX_EN only)
// ----------------------------------------------------------------------------
module quad_encoder_gen #(
    parameter int DIV_W    = 16,
    parameter int POS_W    = 16,
    parameter int IDX_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_valid,
    input  logic                    step_dir,
    output logic                    step_ready,
    input  logic [DIV_W-1:0]        period,
    output logic                    A,
    output logic                    B,
    output logic                    dir,
    output logic signed [POS_W-1:0] position
`ifdef QUAD_GEN_INDEX_EN
    ,
    output logic                    z
`endif
);

    // The index field must fit inside the position counter.
    if (IDX_LOG2 < 1 || IDX_LOG2 > POS_W) begin : g_bad_idx
        $error("quad_encoder_gen: IDX_LOG2 must be in 1..POS_W");
    end

    logic [DIV_W-1:0]        hold_q, hold_d;
    logic                    a_q, a_d;
    logic                    b_q, b_d;
    logic                    dir_q, dir_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    accept;

    // Ready is gated by rst so that no step is taken while reset is held.
    assign step_ready = (hold_q == '0) && rst;
    assign accept     = step_valid && step_ready;

    always_comb begin
        hold_d = hold_q;
        a_d    = a_q;
        b_d    = b_q;
        dir_d  = dir_q;
        pos_d  = pos_q;
        if (accept) begin
            hold_d = period;
            dir_d  = step_dir;
            if (step_dir) begin
                // Forward: 00->01->11->10, i.e. A' = B, B' = ~A
                a_d   = b_q;
                b_d   = ~a_q;
                pos_d = pos_q + POS_W'(1);
            end else begin
                // Reverse: 00->10->11->01, i.e. A' = ~B, B' = A
                a_d   = ~b_q;
                b_d   = a_q;
                pos_d = pos_q - POS_W'(1);
            end
        end else if (hold_q != '0) begin
            hold_d = hold_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            dir_q  <= 1'b0;
            pos_q  <= '0;
        end else begin
            hold_q <= hold_d;
            a_q    <= a_d;
            b_q    <= b_d;
            dir_q  <= dir_d;
            pos_q  <= pos_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign dir      = dir_q;
    assign position = pos_q;

`ifdef QUAD_GEN_INDEX_EN
    logic z_q, z_d;

    // Computed from next position so z changes on the same edge as A/B.
    assign z_d = (pos_d[IDX_LOG2-1:0] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_q <= 1'b1;
        end else begin
            z_q <= z_d;
        end
    end

    assign z = z_q;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// ----------------------------------------------------------------------------
// tb_quad_encoder_gen
//
// Directed testbench for quad_encoder_gen. Builds with IDX_LOG2 = 2 so the
// index output (when QUAD_GEN_INDEX_EN is defined) pulses every 4 counts.
// ----------------------------------------------------------------------------
module tb_quad_encoder_gen;

    localparam int DIV_W = 16;
    localparam int POS_W = 16;

    logic                    clk;
    logic                    rst;
    logic                    step_valid;
    logic                    step_dir;
    logic                    step_ready;
    logic [DIV_W-1:0]        period;
    logic                    A;
    logic                    B;
    logic                    dir;
    logic signed [POS_W-1:0] position;
`ifdef QUAD_GEN_INDEX_EN
    logic                    z;
`endif

    int ncmp;
    int nerr;

    quad_encoder_gen #(
        .DIV_W    (DIV_W),
        .POS_W    (POS_W),
        .IDX_LOG2 (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .step_ready (step_ready),
        .period     (period),
        .A          (A),
        .B          (B),
        .dir        (dir),
        .position   (position)
`ifdef QUAD_GEN_INDEX_EN
        ,
        .z          (z)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference phase for a position: 0->00, 1->01, 2->11, 3->10
    function automatic logic [1:0] ab_of(input logic [15:0] p);
        case (p[1:0])
            2'd0:    ab_of = 2'b00;
            2'd1:    ab_of = 2'b01;
            2'd2:    ab_of = 2'b11;
            default: ab_of = 2'b10;
        endcase
    endfunction

    // Advance one edge and check position, phase and direction.
    task automatic step_chk(input string tag, input logic [15:0] exp_pos, input logic exp_dir);
        @(posedge clk);
        #1;
        chk({tag, "_pos"}, 32'($unsigned(position)), 32'(exp_pos));
        chk({tag, "_ab"},  32'({A, B}),              32'(ab_of(exp_pos)));
        chk({tag, "_dir"}, 32'(dir),                 32'(exp_dir));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ab"},    32'({A, B}),              32'(2'b00));
        chk({tag, "_dir"},   32'(dir),                 32'(1'b0));
        chk({tag, "_pos"},   32'($unsigned(position)), 32'(0));
        chk({tag, "_ready"}, 32'(step_ready),          32'(1'b0));
`ifdef QUAD_GEN_INDEX_EN
        chk({tag, "_z"},     32'(z),                   32'(1'b1));
`endif
    endtask

    initial begin
        ncmp       = 0;
        nerr       = 0;
        rst        = 1'b0;
        step_valid = 1'b0;
        step_dir   = 1'b0;
        period     = '0;

        // Reset state
        #2;
        chk_reset_state("rst0");

        // Full-rate forward stepping, first step on first edge after release
        @(negedge clk);
        rst        = 1'b1;
        period     = 16'd0;
        step_valid = 1'b1;
        step_dir   = 1'b1;
        #1;
        chk("fr_ready0", 32'(step_ready), 32'(1'b1));
        for (int i = 1; i <= 5; i++) begin
            step_chk("fr", 16'(i), 1'b1);
            chk("fr_ready", 32'(step_ready), 32'(1'b1));
        end
        // {A,B} after 5 forward steps
        chk("fr_ab5", 32'({A, B}), 32'(2'b01));

        // Spaced stepping: P=3, one acceptance every 4 cycles
        period = 16'd3;
        step_chk("p3a", 16'd6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("p3_ready_lo", 32'(step_ready), 32'(1'b0));
            chk("p3_ab_hold",  32'({A, B}),     32'(2'b11));
            chk("p3_pos_hold", 32'($unsigned(position)), 32'(6));
            @(posedge clk);
            #1;
        end
        chk("p3_ready_hi", 32'(step_ready), 32'(1'b1));
        step_chk("p3b", 16'd7, 1'b1);
        chk("p3b_ready_lo", 32'(step_ready), 32'(1'b0));
        step_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("p3_idle_ready", 32'(step_ready), 32'(1'b1));
        chk("p3_idle_dir",   32'(dir),        32'(1'b1));

        // Reverse at full rate down to position 2 ({A,B}=11)
        period     = 16'd0;
        step_dir   = 1'b0;
        step_valid = 1'b1;
        for (int p = 6; p >= 2; p--) begin
            step_chk("rev", 16'(p), 1'b0);
        end
        // From 11 one reverse step: only A changes, B stays 1
        step_chk("rev1", 16'd1, 1'b0);
        chk("rev1_ab", 32'({A, B}), 32'(2'b01));

        // Preload to 0x7FFF then cross the signed wrap both ways
        step_dir = 1'b1;
        repeat (32766) @(posedge clk);
        #1;
        chk("pre_pos", 32'($unsigned(position)), 32'(16'h7FFF));
        chk("pre_ab",  32'({A, B}),              32'(2'b10));
        step_chk("wrap_up", 16'h8000, 1'b1);
        chk("wrap_up_ab", 32'({A, B}), 32'(2'b00));
        step_dir = 1'b0;
        step_chk("wrap_dn", 16'h7FFF, 1'b0);
        chk("wrap_dn_ab", 32'({A, B}), 32'(2'b10));

        // Reset asserted mid-hold (P=100, 10 cycles after acceptance)
        period   = 16'd100;
        step_dir = 1'b1;
        step_chk("mh_acc", 16'h8000, 1'b1);
        step_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mh_ready_lo", 32'(step_ready), 32'(1'b0));
        rst        = 1'b0;
        step_valid = 1'b1;
        #1;
        chk_reset_state("mh_rst");
        @(negedge clk);
        chk_reset_state("mh_rst_held");
        rst    = 1'b1;
        period = 16'd0;
        #1;
        chk("mh_ready_rel", 32'(step_ready), 32'(1'b1));
        step_chk("mh_first", 16'd1, 1'b1);

        // Index pulses every 4 counts from a fresh reset
        @(negedge clk);
        rst        = 1'b0;
        step_valid = 1'b0;
        #1;
        chk_reset_state("ix_rst");
        @(negedge clk);
        rst        = 1'b1;
        step_valid = 1'b1;
        step_dir   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step_chk("ix", 16'(i), 1'b1);
`ifdef QUAD_GEN_INDEX_EN
            chk("ix_z", 32'(z), 32'((i % 4) == 0));
`endif
        end
        step_valid = 1'b0;

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    // Hard time limit in case the sequence above stalls
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete within limit");
        $fatal(1, "timeout");
    end

endmodule
